// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, state encoding and opcode map for the A/B CPU
package cpu_pkg;

  localparam int OP_W   = 7;
  localparam int DATA_W = 8;
  localparam int IW     = OP_W + DATA_W;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4
  } state_t;

  // Jumps occupy the top of the opcode map; everything above OP_LAST is undefined.
  localparam logic [OP_W-1:0] OP_JMP_FIRST = 7'h53;
  localparam logic [OP_W-1:0] OP_LAST      = 7'h5B;
  localparam logic [OP_W-1:0] OP_ILL_A     = 7'h49;
  localparam logic [OP_W-1:0] OP_ILL_B     = 7'h4A;

  localparam logic [OP_W-1:0] OP_LDA_K     = 7'h02;
  localparam logic [OP_W-1:0] OP_ADDA_K    = 7'h06;
  localparam logic [OP_W-1:0] OP_MOVA_M    = 7'h25;
  localparam logic [OP_W-1:0] OP_JMP       = 7'h53;

  localparam logic [1:0] SELB_MEM = 2'b11;

  function automatic logic op_is_jump(input logic [OP_W-1:0] op);
    return (op >= OP_JMP_FIRST) && (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/cpu_sequencer_opcode_class.sv
// rtl/cpu_sequencer_opcode_class.sv - classifies an opcode as illegal and/or jump
module opcode_class
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output logic            is_illegal,
  output logic            is_jump
);

  assign is_illegal = (opcode == OP_ILL_A) || (opcode == OP_ILL_B) || (opcode > OP_LAST);
  assign is_jump    = op_is_jump(opcode);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/mem/exec sequencer owning PC and IR
module cpu_sequencer #(
  parameter int                    PC_W     = 8,
  parameter int                    DATA_W   = 8,
  parameter int                    OP_W     = 7,
  parameter int                    IW       = OP_W + DATA_W,
  parameter logic [PC_W-1:0]       RESET_PC = '0,
  parameter int                    RET_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             halt_i,
  output logic             im_req_o,
  output logic [PC_W-1:0]  im_addr_o,
  input  logic             im_valid_i,
  input  logic [IW-1:0]    im_data_i,
  output logic [IW-1:0]    ir_o,
  input  logic             dec_la_i,
  input  logic             dec_lb_i,
  input  logic             dec_lp_i,
  input  logic             dec_mem_we_i,
  input  logic             dec_wbsel_i,
  input  logic [1:0]       dec_selb_i,
  output logic             la_o,
  output logic             lb_o,
  output logic             mem_we_o,
  output logic             flags_we_o,
  output logic             dm_req_o,
  input  logic             dm_valid_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [2:0]       state_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic [RET_W-1:0] retired_o
);

  import cpu_pkg::*;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc;
  logic [IW-1:0]     ir;
  logic              step_mode;
  logic              halt_pending;
  logic              illegal;
  logic [RET_W-1:0]  retired;

  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] literal;
  logic              is_illegal, is_jump;
  logic              mrd;
  logic              start;
  logic              exec;

  assign opcode  = ir[IW-1 -: OP_W];
  assign literal = ir[DATA_W-1:0];
  assign mrd     = dec_wbsel_i | (dec_selb_i == SELB_MEM);
  // halt_i wins over run/step while halted, so a combined request never starts.
  assign start   = (run_i | step_i) & ~halt_i;
  assign exec    = (state == ST_EXEC);

  opcode_class u_opcode_class (
    .opcode     (opcode),
    .is_illegal (is_illegal),
    .is_jump    (is_jump)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_HALT:   if (start) state_next = ST_FETCH;
      ST_FETCH:  if (im_valid_i) state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_illegal)  state_next = ST_HALT;
        else if (mrd)    state_next = ST_MEM;
        else             state_next = ST_EXEC;
      end
      ST_MEM:    if (dm_valid_i) state_next = ST_EXEC;
      ST_EXEC:   state_next = (step_mode | halt_pending | halt_i) ? ST_HALT : ST_FETCH;
      default:   state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_HALT;
      pc           <= RESET_PC;
      ir           <= '0;
      step_mode    <= 1'b0;
      halt_pending <= 1'b0;
      illegal      <= 1'b0;
      retired      <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_HALT: if (start) begin
          step_mode <= ~run_i;
          illegal   <= 1'b0;
        end
        ST_FETCH:  if (im_valid_i) ir <= im_data_i;
        ST_DECODE: if (is_illegal) illegal <= 1'b1;
        ST_EXEC: begin
          pc      <= dec_lp_i ? PC_W'(literal) : pc + 1'b1;
          retired <= retired + 1'b1;
        end
        default: ;
      endcase
      // Entering HALT consumes the request; otherwise latch any new one.
      if (state != ST_HALT && state_next == ST_HALT) halt_pending <= 1'b0;
      else if (state != ST_HALT && halt_i)           halt_pending <= 1'b1;
    end
  end

  assign im_req_o   = (state == ST_FETCH);
  assign im_addr_o  = pc;
  assign dm_req_o   = (state == ST_MEM);
  assign la_o       = exec & dec_la_i;
  assign lb_o       = exec & dec_lb_i;
  assign mem_we_o   = exec & dec_mem_we_i;
  assign flags_we_o = exec & ~is_jump;
  assign ir_o       = ir;
  assign pc_o       = pc;
  assign state_o    = state;
  assign halted_o   = (state == ST_HALT);
  assign illegal_o  = illegal;
  assign retired_o  = retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic        clk, rst;
  logic        run_i, step_i, halt_i;
  logic        im_req_o, im_valid_i;
  logic [7:0]  im_addr_o;
  logic [14:0] im_data_i, ir_o;
  logic        dec_la_i, dec_lb_i, dec_lp_i, dec_mem_we_i, dec_wbsel_i;
  logic [1:0]  dec_selb_i;
  logic        la_o, lb_o, mem_we_o, flags_we_o, dm_req_o, dm_valid_i;
  logic [7:0]  pc_o;
  logic [2:0]  state_o;
  logic        halted_o, illegal_o;
  logic [15:0] retired_o;

  logic [14:0] imem [0:255];
  int total = 0;
  int bad   = 0;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
    .im_req_o(im_req_o), .im_addr_o(im_addr_o), .im_valid_i(im_valid_i), .im_data_i(im_data_i),
    .ir_o(ir_o), .dec_la_i(dec_la_i), .dec_lb_i(dec_lb_i), .dec_lp_i(dec_lp_i),
    .dec_mem_we_i(dec_mem_we_i), .dec_wbsel_i(dec_wbsel_i), .dec_selb_i(dec_selb_i),
    .la_o(la_o), .lb_o(lb_o), .mem_we_o(mem_we_o), .flags_we_o(flags_we_o),
    .dm_req_o(dm_req_o), .dm_valid_i(dm_valid_i), .pc_o(pc_o), .state_o(state_o),
    .halted_o(halted_o), .illegal_o(illegal_o), .retired_o(retired_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Zero-wait instruction memory.
  assign im_valid_i = im_req_o;
  assign im_data_i  = imem[im_addr_o];

  // Minimal decoder stand-in for the opcodes used below.
  always_comb begin
    dec_la_i = 0; dec_lb_i = 0; dec_lp_i = 0; dec_mem_we_i = 0; dec_wbsel_i = 0; dec_selb_i = 2'b00;
    case (ir_o[14:8])
      7'h02, 7'h06: dec_la_i = 1;
      7'h25: begin dec_la_i = 1; dec_wbsel_i = 1; end
      7'h53: dec_lp_i = 1;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_step(output int execs, output logic fl_seen);
    bit done = 0;
    execs = 0; fl_seen = 0;
    step_i = 1;
    for (int c = 1; c <= 20 && !done; c++) begin
      tick();
      step_i = 0;
      if (state_o == 3'd4) execs++;
      if (flags_we_o) fl_seen = 1;
      if (halted_o) done = 1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL step_timeout halted=%0b want 1", halted_o); end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want 0", state_o); end
    total++; if (pc_o !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want 00", pc_o); end
    total++; if (ir_o !== 15'h0) begin bad++; $display("FAIL reset_ir got=%h want 0", ir_o); end
    total++; if ({halted_o, illegal_o, retired_o} !== {1'b1, 1'b0, 16'h0})
      begin bad++; $display("FAIL reset_status got=%b/%b/%0d want 1/0/0", halted_o, illegal_o, retired_o); end
    total++; if ({im_req_o, dm_req_o, la_o, lb_o, mem_we_o, flags_we_o} !== 6'b0)
      begin bad++; $display("FAIL reset_strobes got=%b want 000000", {im_req_o, dm_req_o, la_o, lb_o, mem_we_o, flags_we_o}); end
  endtask

  task automatic test_run_program();
    logic [7:0] la_m = '0, fl_m = '0, pc4 = '0;
    run_i = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      run_i = 0;
      halt_i = (c == 5);
      la_m[c] = la_o; fl_m[c] = flags_we_o;
      if (c == 1) begin
        total++; if ({im_req_o, im_addr_o} !== {1'b1, 8'h00})
          begin bad++; $display("FAIL run_fetch got=%b/%h want 1/00", im_req_o, im_addr_o); end
      end
      if (c == 4) pc4 = pc_o;
    end
    halt_i = 0;
    total++; if (la_m !== 8'b0100_1000) begin bad++; $display("FAIL run_la_cycles got=%b want 01001000", la_m); end
    total++; if (fl_m !== 8'b0100_1000) begin bad++; $display("FAIL run_flags_we got=%b want 01001000", fl_m); end
    total++; if (pc4 !== 8'h01) begin bad++; $display("FAIL run_pc_mid got=%h want 01", pc4); end
    total++; if ({halted_o, pc_o, retired_o} !== {1'b1, 8'h02, 16'd2})
      begin bad++; $display("FAIL run_end got=%b/%h/%0d want 1/02/2", halted_o, pc_o, retired_o); end
  endtask

  task automatic test_mem_wait();
    logic [7:0] dm_m = '0, la_m = '0;
    logic [14:0] ir6 = '0;
    run_i = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      run_i = 0;
      dm_valid_i = (c == 5);
      halt_i = (c == 4);
      dm_m[c] = dm_req_o; la_m[c] = la_o;
      if (c == 6) ir6 = ir_o;
    end
    dm_valid_i = 0; halt_i = 0;
    total++; if (dm_m !== 8'b0011_1000) begin bad++; $display("FAIL mem_dm_req got=%b want 00111000", dm_m); end
    total++; if (la_m !== 8'b0100_0000) begin bad++; $display("FAIL mem_la got=%b want 01000000", la_m); end
    total++; if (ir6 !== {7'h25, 8'h10}) begin bad++; $display("FAIL mem_ir got=%h want %h", ir6, {7'h25, 8'h10}); end
    total++; if ({halted_o, pc_o, retired_o} !== {1'b1, 8'h03, 16'd3})
      begin bad++; $display("FAIL mem_end got=%b/%h/%0d want 1/03/3", halted_o, pc_o, retired_o); end
  endtask

  task automatic test_step_jump_wrap();
    int execs; logic fl;
    do_step(execs, fl);
    total++; if ({execs, fl, pc_o} !== {32'd1, 1'b0, 8'hFF})
      begin bad++; $display("FAIL jmp_to_ff got=%0d/%b/%h want 1/0/ff", execs, fl, pc_o); end
    do_step(execs, fl);
    total++; if ({execs, fl, pc_o, retired_o} !== {32'd1, 1'b0, 8'h40, 16'd5})
      begin bad++; $display("FAIL jmp_at_ff got=%0d/%b/%h/%0d want 1/0/40/5", execs, fl, pc_o, retired_o); end
    do_step(execs, fl);
    imem[8'hFF] = {7'h02, 8'h00};
    do_step(execs, fl);
    total++; if ({execs, fl, pc_o, halted_o, retired_o} !== {32'd1, 1'b1, 8'h00, 1'b1, 16'd7})
      begin bad++; $display("FAIL step_wrap got=%0d/%b/%h/%b/%0d want 1/1/00/1/7", execs, fl, pc_o, halted_o, retired_o); end
  endtask

  task automatic test_illegal_and_restart();
    logic en_seen = 0;
    imem[0] = {7'h4A, 8'h00};
    run_i = 1;
    for (int c = 1; c <= 3; c++) begin
      tick(); run_i = 0;
      if (la_o | lb_o | mem_we_o | flags_we_o) en_seen = 1;
    end
    total++; if ({halted_o, illegal_o, pc_o, retired_o, en_seen} !== {1'b1, 1'b1, 8'h00, 16'd7, 1'b0})
      begin bad++; $display("FAIL illegal got=%b/%b/%h/%0d/%b want 1/1/00/7/0", halted_o, illegal_o, pc_o, retired_o, en_seen); end
    imem[0] = {7'h02, 8'h05};
    run_i = 1; halt_i = 1; tick(); run_i = 0; halt_i = 0;
    total++; if ({halted_o, illegal_o} !== 2'b11)
      begin bad++; $display("FAIL run_with_halt got=%b/%b want 1/1", halted_o, illegal_o); end
    run_i = 1; step_i = 1;
    for (int c = 1; c <= 7; c++) begin
      tick(); run_i = 0; step_i = 0;
      halt_i = (c == 4);
      if (c == 1) begin
        total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b want 0", illegal_o); end
      end
      if (c == 4) begin
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL run_beats_step got=%0d want 1", state_o); end
      end
    end
    halt_i = 0;
    total++; if ({halted_o, pc_o, retired_o} !== {1'b1, 8'h02, 16'd9})
      begin bad++; $display("FAIL restart_end got=%b/%h/%0d want 1/02/9", halted_o, pc_o, retired_o); end
  endtask

  task automatic test_reset_mid_mem();
    logic en_seen = 0;
    run_i = 1;
    for (int c = 1; c <= 3; c++) begin tick(); run_i = 0; end
    total++; if (dm_req_o !== 1'b1) begin bad++; $display("FAIL rstmem_in_mem got=%b want 1", dm_req_o); end
    rst = 1; tick(); rst = 0;
    total++; if ({dm_req_o, state_o, pc_o, retired_o} !== {1'b0, 3'd0, 8'h00, 16'd0})
      begin bad++; $display("FAIL rstmem_after got=%b/%0d/%h/%0d want 0/0/00/0", dm_req_o, state_o, pc_o, retired_o); end
    dm_valid_i = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (la_o | lb_o | !halted_o) en_seen = 1;
    end
    dm_valid_i = 0;
    total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL rstmem_late_valid got=%b want 0", en_seen); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = {7'h4A, 8'h00};
    imem[0]     = {7'h02, 8'h05};
    imem[1]     = {7'h06, 8'h03};
    imem[2]     = {7'h25, 8'h10};
    imem[3]     = {7'h53, 8'hFF};
    imem[8'hFF] = {7'h53, 8'h40};
    imem[8'h40] = {7'h53, 8'hFF};
    rst = 0; run_i = 0; step_i = 0; halt_i = 0; dm_valid_i = 0;
    test_reset();
    test_run_program();
    test_mem_wait();
    test_step_jump_wrap();
    test_illegal_and_restart();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the two-register (A/B) CPU. It owns PC and IR, and handshakes with instruction memory and data memory. It gates the combinational control decoder's LA/LB/LP/mem_we strobes so they fire only in the EXEC cycle, and provides run/step/halt control for the board and the testbench.

Parameters:
PC_W, 8, program counter / instruction address width
DATA_W, 8, literal field width (low bits of IR)
OP_W, 7, opcode field width (high bits of IR)
IW, 15, instruction width (OP_W+DATA_W)
RESET_PC, 0, PC value after reset
RET_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run_i  in  1  pulse: leave HALT and execute continuously
step_i  in  1  pulse: leave HALT and execute exactly one instruction
halt_i  in  1  request stop at next instruction boundary
im_req_o  out  1  instruction fetch request
im_addr_o  out  PC_W  fetch address (= PC)
im_valid_i  in  1  im_data_i valid / fetch done
im_data_i  in  IW  fetched instruction
ir_o  out  IW  instruction register to decoder/datapath
dec_la_i, dec_lb_i, dec_lp_i, dec_mem_we_i  in  1 each  decoder strobes
dec_wbsel_i  in  1  decoder writeback select (1 = memory)
dec_selb_i  in  2  decoder ALU-B select (2'b11 = memory data)
la_o, lb_o, mem_we_o  out  1 each  gated register/memory enables
flags_we_o  out  1  status-register {Z,N,C,V} load
dm_req_o  out  1  data-memory read request
dm_valid_i  in  1  data-memory read data valid
pc_o  out  PC_W  current PC
state_o  out  3  FSM state (debug)
halted_o  out  1  1 while in HALT
illegal_o  out  1  sticky: halted on illegal opcode
retired_o  out  RET_W  instructions retired, wraps

Behaviour:
- Single clock domain clk. Synchronous active-high reset rst. Reset has priority over all inputs, including mid-instruction.
- Reset: state=HALT, pc_o=RESET_PC, ir_o=0, halted_o=1, illegal_o=0, retired_o=0. All request and enable outputs are 0 and deasserted in the cycle after rst. Outstanding im/dm transactions are abandoned; late valid inputs are ignored.
- Opcode = ir[IW-1 -: OP_W]; literal = ir[DATA_W-1:0]. Illegal opcodes: 7'h49, 7'h4A, and anything above 7'h5B. Jump opcodes: 7'h53..7'h5B.
- Memory read needed: mrd = dec_wbsel_i | (dec_selb_i == 2'b11).
- HALT: halted_o=1.
  - run_i → FETCH, continuous mode.
  - step_i → FETCH, step mode.
  - run_i and step_i together: run wins.
  - halt_i together with either: stay in HALT.
  - Leaving HALT clears illegal_o.
- FETCH: im_req_o=1, im_addr_o=pc. On im_valid_i: ir <= im_data_i, go to DECODE. Zero-wait memory gives a 1-cycle FETCH.
- DECODE (1 cycle): decoder outputs settle from IR; the data-memory address (B or literal, datapath side) is presented.
  - Illegal → HALT, illegal_o=1. PC unchanged, no retire.
  - Else mrd → MEM.
  - Else → EXEC.
- MEM: dm_req_o=1 until dm_valid_i, then EXEC. The datapath holds read data stable through EXEC.
- EXEC (exactly 1 cycle):
  - Enables: la_o=dec_la_i, lb_o=dec_lb_i, mem_we_o=dec_mem_we_i. flags_we_o=1 unless the opcode is a jump.
  - PC: pc <= dec_lp_i ? literal : pc+1, modulo 2^PC_W (0xFF+1 → 0x00). Taken-jump condition is already resolved by the decoder from the current flags.
  - retired_o increments, wrapping.
  - Next state: HALT if step mode or halt pending, else FETCH.
- la_o/lb_o/mem_we_o/flags_we_o are 0 in every state other than EXEC.
- halt_i asserted in any non-HALT state sets halt_pending. The current instruction completes; pending clears on entry to HALT.
- im_valid_i outside FETCH and dm_valid_i outside MEM are ignored.
- CPI with zero-wait memories: 3 without a memory read, 4 with one.

Decomposition:
- Shared package cpu_pkg: OP_W/DATA_W/IW constants, state encoding (HALT, FETCH, DECODE, MEM, EXEC), OP_JMP_FIRST=7'h53, OP_LAST=7'h5B, illegal-gap constants, ALU op codes shared with the decoder.
- One natural sub-module, opcode_class: combinational; outputs is_illegal and is_jump from the opcode.

Test Plan:
- Reset, then run_i with zero-wait IM: program {A=K 0x05 (op 0x02), A=A+K 0x03 (op 0x06)} → la_o pulses in cycles 3 and 6; pc_o 0→1→2; retired_o=2; flags_we_o=1 on both EXECs.
- MOV A,[K] (op 0x25, lit 0x10), dm_valid_i after 3 wait cycles → dm_req_o high 3 cycles then low; single la_o pulse in EXEC; instruction total 6 cycles.
- JMP 0x40 (op 0x53, dec_lp_i=1) at pc=0xFF → pc_o=0x40, flags_we_o=0. Non-jump at pc=0xFF → pc_o=0x00.
- step_i from HALT → exactly one EXEC, then halted_o=1, retired_o +1. halt_i asserted mid-MEM → instruction completes, then HALT.
- Fetch opcode 0x4A → HALT, illegal_o=1, pc_o unchanged, no enable pulses. Subsequent run_i clears illegal_o.
- rst asserted during MEM with dm_req_o=1 → next cycle dm_req_o=0, state HALT, pc_o=RESET_PC; late dm_valid_i causes no la_o/lb_o.
